// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: state enum and default PC width.
// Used by fetch_sequencer; no FETCH_CALL_STACK_EN dependence.
package fetch_pkg;

  localparam int PC_W_DEF = 16;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_RUN,
    FS_DONE
  } fs_state_t;

endpackage

// File: rtl/ret_stack.sv
// LIFO of return addresses for the optional call/return feature.
// Instantiated by fetch_sequencer only under FETCH_CALL_STACK_EN.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign dout  = mem[AW'(cnt - CW'(1))];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (push && !full) begin
      mem[AW'(cnt)] <= din;
      cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-program fetch PC sequencer with Start/Done handshake and branches.
// Optional call/return stack enabled by defining FETCH_CALL_STACK_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int NUM_PROGS = 3,
  parameter logic [NUM_PROGS*PC_W-1:0] PROG_BASE =
    {16'd301, 16'd124, 16'd0},
  parameter logic [NUM_PROGS*PC_W-1:0] PROG_LAST =
    {16'd400, 16'd300, 16'd123},
  parameter int STACK_DEPTH = 4,
  localparam int SEL_W =
    (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic            CLK,
  input  logic            Init,
  input  logic            Start,
  input  logic [SEL_W-1:0] Prog_sel,
  input  logic            Stall,
  input  logic            Branch_abs,
  input  logic            Branch_rel_z,
  input  logic            Branch_rel_nz,
  input  logic            ALU_zero,
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] PC,
  output logic            Busy,
  output logic            Done
`ifdef FETCH_CALL_STACK_EN
  ,
  input  logic            Call,
  input  logic            Ret,
  output logic            Stack_err
`endif
);

  fs_state_t        state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d, pc_nx;
  logic [SEL_W-1:0] sel_q, sel_d, launch_sel;
  logic             last_hit, launch;

  function automatic logic [PC_W-1:0] base_of(
    input logic [SEL_W-1:0] s
  );
    return PROG_BASE[s*PC_W +: PC_W];
  endfunction

  assign launch_sel = (int'(Prog_sel) < NUM_PROGS) ? Prog_sel : '0;
  assign last_hit   = (pc_q == PROG_LAST[sel_q*PC_W +: PC_W]);

`ifdef FETCH_CALL_STACK_EN
  logic            push, pop, err_set, err_q;
  logic            st_full, st_empty;
  logic [PC_W-1:0] st_top;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_stack (
    .clk   (CLK),
    .rst   (Init || launch),
    .push  (push),
    .pop   (pop),
    .din   (pc_q + PC_W'(1)),
    .dout  (st_top),
    .full  (st_full),
    .empty (st_empty)
  );

  assign Stack_err = err_q;
`endif

  always_comb begin
    pc_nx = pc_q + PC_W'(1);
    if (Branch_abs)
      pc_nx = Target;
    else if (Branch_rel_z && ALU_zero)
      pc_nx = pc_q + Target;
    else if (Branch_rel_nz && !ALU_zero)
      pc_nx = pc_q + Target;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sel_d   = sel_q;
    launch  = 1'b0;
`ifdef FETCH_CALL_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
`endif
    unique case (state_q)
      FS_IDLE, FS_DONE: begin
        if (Start) begin
          launch  = 1'b1;
          sel_d   = launch_sel;
          pc_d    = base_of(launch_sel);
          state_d = FS_RUN;
        end
      end
      FS_RUN: begin
        if (!Stall) begin
          if (last_hit) begin
            state_d = FS_DONE;
          end else begin
            pc_d = pc_nx;
`ifdef FETCH_CALL_STACK_EN
            // Stack faults abort the program with PC frozen.
            if (Ret) begin
              if (st_empty) begin
                err_set = 1'b1;
                pc_d    = pc_q;
                state_d = FS_DONE;
              end else begin
                pop  = 1'b1;
                pc_d = st_top;
              end
            end else if (Call) begin
              if (st_full) begin
                err_set = 1'b1;
                pc_d    = pc_q;
                state_d = FS_DONE;
              end else begin
                push = 1'b1;
                pc_d = Target;
              end
            end
`endif
          end
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Init) begin
      state_q <= FS_IDLE;
      pc_q    <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sel_q   <= sel_d;
    end
  end

`ifdef FETCH_CALL_STACK_EN
  always_ff @(posedge CLK) begin
    if (Init || launch)
      err_q <= 1'b0;
    else if (err_set)
      err_q <= 1'b1;
  end
`endif

  assign PC   = pc_q;
  assign Busy = (state_q == FS_RUN);
  assign Done = (state_q == FS_DONE);

endmodule
